// File: rtl/axis_pkg.sv
// Shared AXI-Stream constants and arbiter state encoding.
// Imported by the round-robin arbiter and its picker.
package axis_pkg;
  localparam int AXIS_DATA_W = 8;
  localparam int AXIS_DEST_W = 5;

  typedef enum logic {
    ARB_IDLE,
    ARB_PKT
  } arb_state_t;
endpackage

// File: rtl/axis_rr_pick.sv
// Round-robin picker: first requester at or after i_ptr, modulo N.
// Purely combinational so a switch-side arbiter can reuse it.
module axis_rr_pick
  import axis_pkg::*;
#(
  parameter int N     = 2,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_found
);
  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_pos;

  // Walk from the farthest offset down so the nearest requester wins.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    w_sum   = '0;
    w_pos   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_ptr} + (PTR_W + 1)'(k);
      if (w_sum >= (PTR_W + 1)'(N))
        w_sum = w_sum - (PTR_W + 1)'(N);
      w_pos = w_sum[PTR_W-1:0];
      if (i_req[w_pos]) begin
        o_idx   = w_pos;
        o_found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-granular N-to-1 AXI-Stream round-robin arbiter.
// Data path is combinational from the granted source; no storage.
module axis_rr_arbiter
  import axis_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = AXIS_DATA_W,
  parameter int DEST_W  = AXIS_DEST_W
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_SRC-1:0]        i_s_tvalid,
  input  logic [NUM_SRC*DATA_W-1:0] i_s_tdata,
  input  logic [NUM_SRC*DEST_W-1:0] i_s_tdest,
  input  logic [NUM_SRC-1:0]        i_s_tlast,
  output logic [NUM_SRC-1:0]        o_s_tready,
  input  logic                      i_m_tready,
  output logic                      o_m_tvalid,
  output logic [DATA_W-1:0]         o_m_tdata,
  output logic [DEST_W-1:0]         o_m_tdest,
  output logic                      o_m_tlast,
  output logic [NUM_SRC-1:0]        o_grant,
  output logic                      o_busy
);
  localparam int PTR_W = $clog2(NUM_SRC);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [PTR_W-1:0] r_g;
  logic [PTR_W-1:0] w_g_nxt;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;

  logic [PTR_W-1:0] w_pick;
  logic             w_found;

  logic              w_vld;
  logic [DATA_W-1:0] w_data;
  logic [DEST_W-1:0] w_dest;
  logic              w_last;

  axis_rr_pick #(
    .N     (NUM_SRC),
    .PTR_W (PTR_W)
  ) u_pick (
    .i_req   (i_s_tvalid),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick),
    .o_found (w_found)
  );

  always_comb begin
    w_vld  = 1'b0;
    w_data = '0;
    w_dest = '0;
    w_last = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_g == PTR_W'(i)) begin
        w_vld  = i_s_tvalid[i];
        w_data = i_s_tdata[i*DATA_W +: DATA_W];
        w_dest = i_s_tdest[i*DEST_W +: DEST_W];
        w_last = i_s_tlast[i];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ARB_IDLE;
      r_g     <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_g     <= w_g_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_g_nxt     = r_g;
    w_ptr_nxt   = r_ptr;
    o_m_tvalid  = 1'b0;
    o_m_tdata   = '0;
    o_m_tdest   = '0;
    o_m_tlast   = 1'b0;
    o_s_tready  = '0;
    o_grant     = '0;
    o_busy      = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_found) begin
          w_state_nxt = ARB_PKT;
          w_g_nxt     = w_pick;
        end
      end
      ARB_PKT: begin
        o_m_tvalid = w_vld;
        o_m_tdata  = w_data;
        o_m_tdest  = w_dest;
        o_m_tlast  = w_last;
        o_s_tready = NUM_SRC'(i_m_tready) << r_g;
        o_grant    = NUM_SRC'(1) << r_g;
        o_busy     = 1'b1;
        // Release only on an accepted tlast beat.
        if (w_vld && i_m_tready && w_last) begin
          w_state_nxt = ARB_IDLE;
          if (r_g == PTR_W'(NUM_SRC - 1))
            w_ptr_nxt = '0;
          else
            w_ptr_nxt = r_g + PTR_W'(1);
        end
      end
    endcase
  end
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed table-driven bench for axis_rr_arbiter (2 and 4 sources).
// Inputs change on negedge; outputs are checked 1ns later.
module tb_axis_rr_arbiter;
  typedef struct {
    logic       rst;
    logic [1:0] v;
    logic [7:0] d1;
    logic [7:0] d0;
    logic [1:0] l;
    logic       mtr;
    logic       mv;
    logic [7:0] md;
    logic [4:0] mdst;
    logic       ml;
    logic [1:0] str;
    logic [1:0] g;
    logic       busy;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  s_tvalid;
  logic [15:0] s_tdata;
  logic [9:0]  s_tdest;
  logic [1:0]  s_tlast;
  logic [1:0]  s_tready;
  logic        m_tready;
  logic        m_tvalid;
  logic [7:0]  m_tdata;
  logic [4:0]  m_tdest;
  logic        m_tlast;
  logic [1:0]  grant;
  logic        busy;

  logic        rst4;
  logic [3:0]  s4_tvalid;
  logic [31:0] s4_tdata;
  logic [19:0] s4_tdest;
  logic [3:0]  s4_tlast;
  logic [3:0]  s4_tready;
  logic        m4_tready;
  logic        m4_tvalid;
  logic [7:0]  m4_tdata;
  logic [4:0]  m4_tdest;
  logic        m4_tlast;
  logic [3:0]  grant4;
  logic        busy4;

  int n_vec = 0;
  int n_bad = 0;

  axis_rr_arbiter #(.NUM_SRC(2), .DATA_W(8), .DEST_W(5)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_s_tvalid (s_tvalid),
    .i_s_tdata  (s_tdata),
    .i_s_tdest  (s_tdest),
    .i_s_tlast  (s_tlast),
    .o_s_tready (s_tready),
    .i_m_tready (m_tready),
    .o_m_tvalid (m_tvalid),
    .o_m_tdata  (m_tdata),
    .o_m_tdest  (m_tdest),
    .o_m_tlast  (m_tlast),
    .o_grant    (grant),
    .o_busy     (busy)
  );

  axis_rr_arbiter #(.NUM_SRC(4), .DATA_W(8), .DEST_W(5)) dut4 (
    .i_clk      (clk),
    .i_rst      (rst4),
    .i_s_tvalid (s4_tvalid),
    .i_s_tdata  (s4_tdata),
    .i_s_tdest  (s4_tdest),
    .i_s_tlast  (s4_tlast),
    .o_s_tready (s4_tready),
    .i_m_tready (m4_tready),
    .o_m_tvalid (m4_tvalid),
    .o_m_tdata  (m4_tdata),
    .o_m_tdest  (m4_tdest),
    .o_m_tlast  (m4_tlast),
    .o_grant    (grant4),
    .o_busy     (busy4)
  );

  function automatic vec_t mk(
    input logic rst_i, input logic [1:0] v_i,
    input logic [7:0] d1_i, input logic [7:0] d0_i,
    input logic [1:0] l_i, input logic mtr_i,
    input logic mv_i, input logic [7:0] md_i,
    input logic [4:0] mdst_i, input logic ml_i,
    input logic [1:0] str_i, input logic [1:0] g_i,
    input logic busy_i);
    vec_t r;
    r.rst = rst_i; r.v = v_i; r.d1 = d1_i; r.d0 = d0_i;
    r.l = l_i; r.mtr = mtr_i; r.mv = mv_i; r.md = md_i;
    r.mdst = mdst_i; r.ml = ml_i; r.str = str_i;
    r.g = g_i; r.busy = busy_i;
    return r;
  endfunction

  vec_t tbl[$];
  logic [3:0] exp4[10];
  logic [20:0] act;
  logic [20:0] expv;

  initial begin
    // Reset held with every source valid
    tbl.push_back(mk(1, 2'b11, 8'hB0, 8'hA0, 2'b00, 1, 0, 8'h00, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(mk(1, 2'b11, 8'hB0, 8'hA0, 2'b00, 1, 0, 8'h00, 0, 0, 2'b00, 2'b00, 0));
    // src0 3-beat packet
    tbl.push_back(mk(0, 2'b01, 8'h00, 8'h11, 2'b00, 1, 0, 8'h00, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 2'b01, 8'h00, 8'h11, 2'b00, 1, 1, 8'h11, 1, 0, 2'b01, 2'b01, 1));
    tbl.push_back(mk(0, 2'b01, 8'h00, 8'h22, 2'b00, 1, 1, 8'h22, 1, 0, 2'b01, 2'b01, 1));
    tbl.push_back(mk(0, 2'b01, 8'h00, 8'h33, 2'b01, 1, 1, 8'h33, 1, 1, 2'b01, 2'b01, 1));
    tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 1, 0, 8'h00, 0, 0, 2'b00, 2'b00, 0));
    // Reset, then both sources contend: src0, src1 (with stall), src0
    tbl.push_back(mk(1, 2'b00, 8'h00, 8'h00, 2'b00, 1, 0, 8'h00, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 2'b11, 8'hB0, 8'hA0, 2'b00, 1, 0, 8'h00, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 2'b11, 8'hB0, 8'hA0, 2'b00, 1, 1, 8'hA0, 1, 0, 2'b01, 2'b01, 1));
    tbl.push_back(mk(0, 2'b11, 8'hB0, 8'hA1, 2'b01, 1, 1, 8'hA1, 1, 1, 2'b01, 2'b01, 1));
    tbl.push_back(mk(0, 2'b11, 8'hB0, 8'hC0, 2'b00, 1, 0, 8'h00, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 2'b11, 8'hB0, 8'hC0, 2'b00, 1, 1, 8'hB0, 3, 0, 2'b10, 2'b10, 1));
    tbl.push_back(mk(0, 2'b11, 8'hB1, 8'hC0, 2'b10, 0, 1, 8'hB1, 3, 1, 2'b00, 2'b10, 1));
    tbl.push_back(mk(0, 2'b11, 8'hB1, 8'hC0, 2'b10, 0, 1, 8'hB1, 3, 1, 2'b00, 2'b10, 1));
    tbl.push_back(mk(0, 2'b11, 8'hB1, 8'hC0, 2'b10, 1, 1, 8'hB1, 3, 1, 2'b10, 2'b10, 1));
    tbl.push_back(mk(0, 2'b11, 8'hD0, 8'hC0, 2'b00, 1, 0, 8'h00, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 2'b11, 8'hD0, 8'hC0, 2'b00, 1, 1, 8'hC0, 1, 0, 2'b01, 2'b01, 1));
    tbl.push_back(mk(0, 2'b11, 8'hD0, 8'hC1, 2'b01, 1, 1, 8'hC1, 1, 1, 2'b01, 2'b01, 1));
    // src1 4-beat packet cut by reset after beat 2
    tbl.push_back(mk(0, 2'b11, 8'hE0, 8'hF0, 2'b00, 1, 0, 8'h00, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 2'b11, 8'hE0, 8'hF0, 2'b00, 1, 1, 8'hE0, 3, 0, 2'b10, 2'b10, 1));
    tbl.push_back(mk(0, 2'b11, 8'hE1, 8'hF0, 2'b00, 1, 1, 8'hE1, 3, 0, 2'b10, 2'b10, 1));
    tbl.push_back(mk(1, 2'b11, 8'hE2, 8'hF0, 2'b00, 1, 1, 8'hE2, 3, 0, 2'b10, 2'b10, 1));
    tbl.push_back(mk(0, 2'b11, 8'hE2, 8'hF0, 2'b00, 1, 0, 8'h00, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 2'b11, 8'hE2, 8'hF0, 2'b00, 1, 1, 8'hF0, 1, 0, 2'b01, 2'b01, 1));
    // Granted source drops tvalid mid-packet: grant held
    tbl.push_back(mk(0, 2'b10, 8'hE2, 8'hF1, 2'b00, 1, 0, 8'hF1, 1, 0, 2'b01, 2'b01, 1));
    tbl.push_back(mk(0, 2'b11, 8'hE2, 8'hF1, 2'b01, 1, 1, 8'hF1, 1, 1, 2'b01, 2'b01, 1));
    tbl.push_back(mk(0, 2'b00, 8'h00, 8'h00, 2'b00, 1, 0, 8'h00, 0, 0, 2'b00, 2'b00, 0));

    exp4 = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000,
             4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};

    rst       = 1'b1;
    s_tvalid  = 2'b11;
    s_tdata   = 16'hB0A0;
    s_tdest   = {5'd3, 5'd1};
    s_tlast   = 2'b00;
    m_tready  = 1'b1;
    rst4      = 1'b1;
    s4_tvalid = 4'b1111;
    s4_tdata  = 32'h4433_2211;
    s4_tdest  = {5'd4, 5'd3, 5'd2, 5'd1};
    s4_tlast  = 4'b1111;
    m4_tready = 1'b1;
    @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst      = tbl[i].rst;
      s_tvalid = tbl[i].v;
      s_tdata  = {tbl[i].d1, tbl[i].d0};
      s_tlast  = tbl[i].l;
      m_tready = tbl[i].mtr;
      #1;
      act  = {m_tvalid, m_tdata, m_tdest, m_tlast,
              s_tready, grant, busy};
      expv = {tbl[i].mv, tbl[i].md, tbl[i].mdst, tbl[i].ml,
              tbl[i].str, tbl[i].g, tbl[i].busy};
      n_vec++;
      if (act !== expv) begin
        n_bad++;
        $display("FAIL vec%0d got v=%b d=%h dst=%0d l=%b rdy=%b g=%b b=%b want v=%b d=%h dst=%0d l=%b rdy=%b g=%b b=%b",
          i, m_tvalid, m_tdata, m_tdest, m_tlast, s_tready, grant, busy,
          tbl[i].mv, tbl[i].md, tbl[i].mdst, tbl[i].ml,
          tbl[i].str, tbl[i].g, tbl[i].busy);
      end
    end

    // Four sources, single-beat packets, pointer wraps 3 -> 0
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) rst4 = 1'b0;
      #1;
      n_vec++;
      if ({busy4, grant4} !== {|exp4[i], exp4[i]}) begin
        n_bad++;
        $display("FAIL rr4 step%0d got busy=%b grant=%b want busy=%b grant=%b",
          i, busy4, grant4, |exp4[i], exp4[i]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
